// File: rtl/dllp_retry_slot_ctrl.sv
// Retry-buffer slot owner for the DLL transmit path: grants slots, purges on ACK/NAK,
// sequences replays on NAK or replay-timer expiry and requests retrain after too many replays.
module dllp_retry_slot_ctrl #(
  parameter int NUM_SLOTS      = 4,
  parameter int SEQ_WIDTH      = 12,
  parameter int REPLAY_TIMEOUT = 1024,
  parameter int REPLAY_NUM_MAX = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  output logic                 retry_available_o,
  output logic [7:0]           retry_index_o,
  input  logic                 tlp_commit_i,
  input  logic [SEQ_WIDTH-1:0] tlp_seq_i,
  input  logic                 ack_valid_i,
  output logic                 ack_ready_o,
  input  logic                 ack_nak_i,
  input  logic [SEQ_WIDTH-1:0] ack_seq_i,
  output logic                 replay_valid_o,
  output logic [7:0]           replay_index_o,
  input  logic                 replay_ready_i,
  output logic                 retrain_req_o,
  output logic [7:0]           outstanding_o,
  output logic                 overflow_err_o
);

  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int TMR_W = (REPLAY_TIMEOUT > 1) ? $clog2(REPLAY_TIMEOUT) : 1;
  localparam int RN_W  = (REPLAY_NUM_MAX > 0) ? $clog2(REPLAY_NUM_MAX + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PURGE,
    ST_REPLAY
  } state_t;

  state_t               state_q, state_d;
  // Pointers carry one extra wrap bit so a full queue (head==tail low bits) stays distinguishable.
  logic [CNT_W-1:0]     head_q, head_d;
  logic [CNT_W-1:0]     tail_q, tail_d;
  logic [CNT_W-1:0]     idx_q, idx_d;
  logic [CNT_W-1:0]     end_q, end_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [RN_W-1:0]      replay_num_q, replay_num_d;
  logic [SEQ_WIDTH-1:0] ack_seq_q, ack_seq_d;
  logic                 ack_nak_q, ack_nak_d;
  logic                 retry_avail_q, retry_avail_d;
  logic                 retrain_q, retrain_d;
  logic                 overflow_q, overflow_d;

  logic [SEQ_WIDTH-1:0] seq_mem [NUM_SLOTS];

  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     count_d;
  logic                 full;
  logic                 commit_ok;
  logic                 ack_hs;
  logic [SEQ_WIDTH-1:0] head_seq;
  logic [SEQ_WIDTH-1:0] seq_diff;
  logic                 purge_hit;
  logic                 timer_expired;
  logic                 enter_replay;

  assign count         = tail_q - head_q;
  assign full          = (count == CNT_W'(NUM_SLOTS));
  assign commit_ok     = tlp_commit_i && !full;
  assign ack_hs        = ack_valid_i && (state_q == ST_IDLE);
  assign head_seq      = seq_mem[head_q[PTR_W-1:0]];
  // Modular distance: ack covers head when it lies in the half-space at or ahead of head.
  assign seq_diff      = ack_seq_q - head_seq;
  assign purge_hit     = (count != '0) && !seq_diff[SEQ_WIDTH-1];
  assign timer_expired = (timer_q == TMR_W'(REPLAY_TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = commit_ok ? tail_q + CNT_W'(1) : tail_q;
    idx_d        = idx_q;
    end_d        = end_q;
    timer_d      = timer_q;
    replay_num_d = replay_num_q;
    ack_seq_d    = ack_seq_q;
    ack_nak_d    = ack_nak_q;
    retrain_d    = 1'b0;
    overflow_d   = overflow_q | (tlp_commit_i && full);
    enter_replay = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ack_hs) begin
          ack_seq_d = ack_seq_i;
          ack_nak_d = ack_nak_i;
          state_d   = ST_PURGE;
        end else if (count != '0) begin
          if (timer_expired) enter_replay = 1'b1;
          else               timer_d      = timer_q + TMR_W'(1);
        end
      end
      ST_PURGE: begin
        if (purge_hit) begin
          head_d       = head_q + CNT_W'(1);
          timer_d      = '0;
          replay_num_d = '0;
        end else if (ack_nak_q) begin
          enter_replay = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REPLAY: begin
        if (idx_q == end_q)      state_d = ST_IDLE;
        else if (replay_ready_i) idx_d   = idx_q + CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase

    if (count == '0) timer_d = '0;

    // Replay set is frozen to what was outstanding before this cycle's commit.
    if (enter_replay) begin
      state_d = ST_REPLAY;
      idx_d   = head_q;
      end_d   = tail_q;
      timer_d = '0;
      if (replay_num_q == RN_W'(REPLAY_NUM_MAX)) begin
        retrain_d    = 1'b1;
        replay_num_d = '0;
      end else begin
        replay_num_d = replay_num_q + RN_W'(1);
      end
    end

    count_d       = tail_d - head_d;
    retry_avail_d = (state_d == ST_IDLE) && (count_d < CNT_W'(NUM_SLOTS));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      head_q        <= '0;
      tail_q        <= '0;
      idx_q         <= '0;
      end_q         <= '0;
      timer_q       <= '0;
      replay_num_q  <= '0;
      ack_seq_q     <= '0;
      ack_nak_q     <= 1'b0;
      retry_avail_q <= 1'b1;
      retrain_q     <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      idx_q         <= idx_d;
      end_q         <= end_d;
      timer_q       <= timer_d;
      replay_num_q  <= replay_num_d;
      ack_seq_q     <= ack_seq_d;
      ack_nak_q     <= ack_nak_d;
      retry_avail_q <= retry_avail_d;
      retrain_q     <= retrain_d;
      overflow_q    <= overflow_d;
    end
  end

  // Slot contents need no reset; validity is defined purely by head/tail.
  always_ff @(posedge clk_i) begin
    if (commit_ok) seq_mem[tail_q[PTR_W-1:0]] <= tlp_seq_i;
  end

  assign retry_available_o = retry_avail_q;
  assign retry_index_o     = 8'(tail_q[PTR_W-1:0]);
  assign ack_ready_o       = (state_q == ST_IDLE);
  assign replay_valid_o    = (state_q == ST_REPLAY) && (idx_q != end_q);
  assign replay_index_o    = 8'(idx_q[PTR_W-1:0]);
  assign retrain_req_o     = retrain_q;
  assign outstanding_o     = 8'(count);
  assign overflow_err_o    = overflow_q;

endmodule

// File: tb/tb_dllp_retry_slot_ctrl.sv
// Directed self-checking bench for dllp_retry_slot_ctrl with default parameters.
module tb_dllp_retry_slot_ctrl;

  logic        clk_i;
  logic        rst_ni;
  logic        retry_available_o;
  logic [7:0]  retry_index_o;
  logic        tlp_commit_i;
  logic [11:0] tlp_seq_i;
  logic        ack_valid_i;
  logic        ack_ready_o;
  logic        ack_nak_i;
  logic [11:0] ack_seq_i;
  logic        replay_valid_o;
  logic [7:0]  replay_index_o;
  logic        replay_ready_i;
  logic        retrain_req_o;
  logic [7:0]  outstanding_o;
  logic        overflow_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  dllp_retry_slot_ctrl dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .retry_available_o(retry_available_o),
    .retry_index_o    (retry_index_o),
    .tlp_commit_i     (tlp_commit_i),
    .tlp_seq_i        (tlp_seq_i),
    .ack_valid_i      (ack_valid_i),
    .ack_ready_o      (ack_ready_o),
    .ack_nak_i        (ack_nak_i),
    .ack_seq_i        (ack_seq_i),
    .replay_valid_o   (replay_valid_o),
    .replay_index_o   (replay_index_o),
    .replay_ready_i   (replay_ready_i),
    .retrain_req_o    (retrain_req_o),
    .outstanding_o    (outstanding_o),
    .overflow_err_o   (overflow_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic bound_fail(input string tag);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got timeout expected event", tag);
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_ni         = 1'b0;
    tlp_commit_i   = 1'b0;
    tlp_seq_i      = '0;
    ack_valid_i    = 1'b0;
    ack_nak_i      = 1'b0;
    ack_seq_i      = '0;
    replay_ready_i = 1'b0;
    repeat (2) cyc();
    rst_ni = 1'b1;
    $display("reset");
  endtask

  task automatic commit(input logic [11:0] seq);
    $display("commit seq=%0d slot=%0d", seq, retry_index_o);
    tlp_commit_i = 1'b1;
    tlp_seq_i    = seq;
    cyc();
    tlp_commit_i = 1'b0;
  endtask

  task automatic send_ack(input logic nak, input logic [11:0] seq);
    int n;
    n = 0;
    while (!ack_ready_o && n < 50) begin
      cyc();
      n++;
    end
    if (!ack_ready_o) bound_fail("ack_ready_wait");
    $display("%s seq=%0d", nak ? "nak" : "ack", seq);
    ack_valid_i = 1'b1;
    ack_nak_i   = nak;
    ack_seq_i   = seq;
    cyc();
    ack_valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!ack_ready_o && n < 50) begin
      cyc();
      n++;
    end
    if (!ack_ready_o) bound_fail("idle_wait");
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (!replay_valid_o && n < bound) begin
      cyc();
      n++;
    end
    if (!replay_valid_o) bound_fail("replay_valid_wait");
  endtask

  task automatic expect_replay(input logic [7:0] exp_idx);
    int n;
    wait_valid(20, n);
    $display("replay slot=%0d", replay_index_o);
    check_eq("replay_index", replay_index_o, exp_idx);
    replay_ready_i = 1'b1;
    cyc();
    replay_ready_i = 1'b0;
  endtask

  initial begin
    int n;
    logic [11:0] wrap_seqs [3];
    wrap_seqs[0] = 12'd4094;
    wrap_seqs[1] = 12'd4095;
    wrap_seqs[2] = 12'd0;

    // Reset values, fill, overflow
    do_reset();
    check_eq("rst_retry_available", retry_available_o, 1);
    check_eq("rst_retry_index", retry_index_o, 0);
    check_eq("rst_outstanding", outstanding_o, 0);
    check_eq("rst_replay_valid", replay_valid_o, 0);
    check_eq("rst_retrain", retrain_req_o, 0);
    check_eq("rst_overflow", overflow_err_o, 0);
    for (int i = 0; i < 4; i++) begin
      check_eq("fill_index", retry_index_o, i);
      commit(12'(i));
    end
    check_eq("full_outstanding", outstanding_o, 4);
    check_eq("full_available", retry_available_o, 0);
    check_eq("full_no_overflow", overflow_err_o, 0);
    commit(12'd4);
    check_eq("drop_outstanding", outstanding_o, 4);
    check_eq("drop_overflow", overflow_err_o, 1);
    cyc();
    check_eq("overflow_sticky", overflow_err_o, 1);

    // ACK seq 1 purges two slots over two cycles; stale NAK then replays from head=2
    do_reset();
    for (int i = 0; i < 4; i++) commit(12'(i));
    send_ack(1'b0, 12'd1);
    check_eq("purge_c0_outstanding", outstanding_o, 4);
    cyc();
    check_eq("purge_c1_outstanding", outstanding_o, 3);
    cyc();
    check_eq("purge_c2_outstanding", outstanding_o, 2);
    cyc();
    check_eq("purge_done_ready", ack_ready_o, 1);
    check_eq("purge_done_available", retry_available_o, 1);
    send_ack(1'b1, 12'd1);
    expect_replay(8'd2);
    expect_replay(8'd3);
    check_eq("replay_end_valid", replay_valid_o, 0);
    wait_idle();
    check_eq("after_replay_outstanding", outstanding_o, 2);

    // Sequence wrap 4094,4095,0 fully acked by 0; stale 4000 changes nothing
    do_reset();
    for (int i = 0; i < 3; i++) commit(wrap_seqs[i]);
    send_ack(1'b0, 12'd0);
    wait_idle();
    check_eq("wrap_outstanding", outstanding_o, 0);
    commit(12'd1);
    check_eq("wrap_tail_index", retry_index_o, 0);
    send_ack(1'b0, 12'd4000);
    wait_idle();
    check_eq("stale_outstanding", outstanding_o, 1);

    // NAK 5 purges seq 5 and replays slots 1,2 with back-pressure
    do_reset();
    commit(12'd5);
    commit(12'd6);
    commit(12'd7);
    send_ack(1'b1, 12'd5);
    wait_valid(20, n);
    for (int i = 0; i < 3; i++) begin
      check_eq("stall_valid", replay_valid_o, 1);
      check_eq("stall_index", replay_index_o, 1);
      cyc();
    end
    expect_replay(8'd1);
    expect_replay(8'd2);
    wait_idle();
    check_eq("nak_outstanding", outstanding_o, 2);

    // Replay timer: first expiry exactly 1024 cycles after commit, retrain on the 4th, none on the 5th
    do_reset();
    commit(12'd9);
    for (int r = 1; r <= 5; r++) begin
      wait_valid(1100, n);
      if (r == 1) check_eq("timeout_cycles", n, 1024);
      $display("timeout replay %0d after %0d cycles", r, n);
      check_eq("timeout_retrain", retrain_req_o, (r == 4) ? 1 : 0);
      expect_replay(8'd0);
      check_eq("retrain_pulse_end", retrain_req_o, 0);
    end
    wait_idle();
    check_eq("timeout_outstanding", outstanding_o, 1);

    // Commit during replay is outside the replay set; reset mid-replay clears everything
    do_reset();
    commit(12'd10);
    commit(12'd11);
    send_ack(1'b1, 12'd9);
    wait_valid(20, n);
    commit(12'd12);
    check_eq("replay_commit_outstanding", outstanding_o, 3);
    check_eq("replay_commit_available", retry_available_o, 0);
    expect_replay(8'd0);
    expect_replay(8'd1);
    check_eq("replay_set_end", replay_valid_o, 0);
    wait_idle();
    check_eq("replay_set_available", retry_available_o, 1);
    commit(12'd13);
    commit(12'd14);
    check_eq("refill_overflow", overflow_err_o, 1);
    send_ack(1'b1, 12'd9);
    expect_replay(8'd0);
    wait_valid(20, n);
    check_eq("full_replay_index", replay_index_o, 1);
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    $display("reset mid-replay");
    check_eq("midrst_replay_valid", replay_valid_o, 0);
    check_eq("midrst_outstanding", outstanding_o, 0);
    check_eq("midrst_overflow", overflow_err_o, 0);
    check_eq("midrst_available", retry_available_o, 1);
    check_eq("midrst_index", retry_index_o, 0);
    check_eq("midrst_ready", ack_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
